// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for a mixed ARM / RISC-V decode stage: per-register
// result countdowns drive decode/fetch stalls, bypass selects and a stall counter.
module hazard_scoreboard #(
   parameter int REG_W   = 5,
   parameter int MAX_LAT = 4,
   parameter int PERF_W  = 32,
   parameter int ARM_PC  = 15
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         arm_i,
   input  logic                         issue_i,
   input  logic [REG_W-1:0]             rs1_i,
   input  logic [REG_W-1:0]             rs2_i,
   input  logic                         rs1_en_i,
   input  logic                         rs2_en_i,
   input  logic [REG_W-1:0]             rd_i,
   input  logic                         rd_en_i,
   input  logic [$clog2(MAX_LAT+1)-1:0] lat_i,
   output logic                         stall_d_o,
   output logic                         stall_f_o,
   output logic                         fwd_a_o,
   output logic                         fwd_b_o,
   output logic                         pc_pending_o,
   output logic [2**REG_W-1:0]          busy_o,
   output logic [PERF_W-1:0]            stall_cnt_o
);
   localparam int               LAT_W  = $clog2(MAX_LAT + 1);
   localparam int               NREG   = 2**REG_W;
   localparam logic [REG_W-1:0] PC_IDX = REG_W'(ARM_PC);

   logic [LAT_W-1:0]  cnt_r [NREG];
   logic [PERF_W-1:0] stall_cnt_r;
   logic [LAT_W-1:0]  c1_s, c2_s, cd_s, cpc_s;
   logic              x0_1_s, x0_2_s, rd_trk_s;
   logic              rdy1_s, rdy2_s, waw_s, stall_d_s, accept_s;

   function automatic logic src_ready(input logic en, input logic x0, input logic [LAT_W-1:0] c);
      return !en || x0 || (c <= LAT_W'(1));
   endfunction

   function automatic logic src_fwd(input logic en, input logic x0, input logic [LAT_W-1:0] c);
      return en && !x0 && (c == LAT_W'(1));
   endfunction

   // Decode-side lookups; while reset is asserted every lookup sees the cleared state.
   always_comb begin
      if (rst) begin
         c1_s  = cnt_r[rs1_i];
         c2_s  = cnt_r[rs2_i];
         cd_s  = cnt_r[rd_i];
         cpc_s = cnt_r[PC_IDX];
      end else begin
         c1_s  = {LAT_W{1'b0}};
         c2_s  = {LAT_W{1'b0}};
         cd_s  = {LAT_W{1'b0}};
         cpc_s = {LAT_W{1'b0}};
      end
      x0_1_s    = !arm_i && (rs1_i == {REG_W{1'b0}});
      x0_2_s    = !arm_i && (rs2_i == {REG_W{1'b0}});
      rd_trk_s  = rd_en_i && (lat_i != {LAT_W{1'b0}}) && (arm_i || (rd_i != {REG_W{1'b0}}));
      rdy1_s    = src_ready(rs1_en_i, x0_1_s, c1_s);
      rdy2_s    = src_ready(rs2_en_i, x0_2_s, c2_s);
      waw_s     = rd_trk_s && (cd_s > lat_i);
      stall_d_s = issue_i && (!rdy1_s || !rdy2_s || waw_s);
      accept_s  = issue_i && !stall_d_s;
   end

   // Busy vector mirrors nonzero counters.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         busy_o[r] = rst && (cnt_r[r] != {LAT_W{1'b0}});
      end
   end

   assign stall_d_o    = stall_d_s;
   assign pc_pending_o = arm_i && (cpc_s != {LAT_W{1'b0}});
   assign stall_f_o    = stall_d_s || pc_pending_o;
   assign fwd_a_o      = src_fwd(rs1_en_i, x0_1_s, c1_s);
   assign fwd_b_o      = src_fwd(rs2_en_i, x0_2_s, c2_s);
   assign stall_cnt_o  = stall_cnt_r;

   // Per-register countdown; an accepted load wins over the decrement.
   always_ff @(posedge clk) begin
      for (int r = 0; r < NREG; r++) begin
         if (!rst) begin
            cnt_r[r] <= {LAT_W{1'b0}};
         end else if (accept_s && rd_trk_s && (rd_i == REG_W'(r))) begin
            cnt_r[r] <= lat_i;
         end else if (cnt_r[r] != {LAT_W{1'b0}}) begin
            cnt_r[r] <= cnt_r[r] - LAT_W'(1);
         end else begin
            cnt_r[r] <= cnt_r[r];
         end
      end
   end

   // Saturating count of decode-stall cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_r <= {PERF_W{1'b0}};
      end else if (stall_d_s && (stall_cnt_r != {PERF_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + PERF_W'(1);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end
endmodule
